// File: rtl/data_memory_mmio.sv
// Data-memory slave for the EX/MEM stage: word RAM with combinational reads plus a
// UART MMIO window (RX data, TX data, status), each UART direction buffered by a FIFO.
module data_memory_mmio #(
  parameter int          RAM_LOG2  = 12,
  parameter int          FIFO_LOG2 = 4,
  parameter logic [31:0] MMIO_RX   = 32'hF000_0000,
  parameter logic [31:0] MMIO_TX   = 32'hF000_0001,
  parameter logic [31:0] MMIO_STAT = 32'hF000_0002
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        i_en,
  input  logic        i_we,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd_inst,
  output logic [31:0] o_rd,
  output logic        o_stall,
  input  logic        i_rx_valid,
  input  logic [7:0]  i_rx_data,
  output logic        o_tx_valid,
  output logic [7:0]  o_tx_data,
  input  logic        i_tx_ready,
  output logic [1:0]  o_dbg_state
);

  // Handshake: the master holds en/we/addr/wd stable while o_stall=1; an access
  // completes in the first cycle it is presented with o_stall=0. UART RX bytes are
  // offered for one cycle on i_rx_valid (no backpressure); TX bytes move on
  // o_tx_valid && i_tx_ready.

  localparam int RAM_DEPTH = 1 << RAM_LOG2;
  localparam int DEPTH     = 1 << FIFO_LOG2;
  localparam logic [FIFO_LOG2:0]   CNT_FULL = (FIFO_LOG2+1)'(DEPTH);
  localparam logic [FIFO_LOG2:0]   CNT_ONE  = (FIFO_LOG2+1)'(1);
  localparam logic [FIFO_LOG2-1:0] PTR_ONE  = FIFO_LOG2'(1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_RX = 2'd1,
    DONE_RX = 2'd2,
    WAIT_TX = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [31:0] r_mem [RAM_DEPTH];
  logic [31:0] r_rd;
  logic        r_overrun;

  logic [7:0]           r_rx_buf [DEPTH];
  logic [FIFO_LOG2-1:0] r_rx_wp;
  logic [FIFO_LOG2-1:0] r_rx_rp;
  logic [FIFO_LOG2:0]   r_rx_cnt;

  logic [7:0]           r_tx_buf [DEPTH];
  logic [FIFO_LOG2-1:0] r_tx_wp;
  logic [FIFO_LOG2-1:0] r_tx_rp;
  logic [FIFO_LOG2:0]   r_tx_cnt;

  logic [RAM_LOG2-1:0] w_idx;
  logic                w_is_mmio;
  logic                w_ram_we;
  logic                w_rx_empty;
  logic                w_rx_full;
  logic                w_rx_push;
  logic                w_rx_pop;
  logic [7:0]          w_rx_head;
  logic                w_tx_empty;
  logic                w_tx_full;
  logic                w_tx_push;
  logic                w_tx_pop;
  logic [31:0]         w_stat;
  logic                w_stall;
  logic                w_capture;
  logic [31:0]         w_rd_inst;

  assign w_idx      = i_addr[RAM_LOG2-1:0];
  assign w_is_mmio  = (i_addr[31:28] == 4'hF);

  assign w_rx_empty = (r_rx_cnt == '0);
  assign w_rx_full  = (r_rx_cnt == CNT_FULL);
  assign w_rx_head  = r_rx_buf[r_rx_rp];
  assign w_rx_push  = i_rx_valid && !w_rx_full;

  assign w_tx_empty = (r_tx_cnt == '0);
  assign w_tx_full  = (r_tx_cnt == CNT_FULL);
  assign w_tx_pop   = !w_tx_empty && i_tx_ready;

  assign w_stat     = {29'b0, r_overrun, !w_tx_full, !w_rx_empty};

  // RAM stores only complete from IDLE; a held request in a wait state is MMIO.
  assign w_ram_we   = !reset && (r_state == IDLE) && i_en && i_we && !w_is_mmio;

  always_comb begin
    w_next    = r_state;
    w_stall   = 1'b0;
    w_rd_inst = '0;
    w_rx_pop  = 1'b0;
    w_tx_push = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_en && !i_we) begin
          if (!w_is_mmio) begin
            w_rd_inst = r_mem[w_idx];
          end else if (i_addr == MMIO_RX) begin
            if (!w_rx_empty) begin
              w_rd_inst = {24'b0, w_rx_head};
              w_rx_pop  = 1'b1;
            end else begin
              w_stall = 1'b1;
              w_next  = WAIT_RX;
            end
          end else if (i_addr == MMIO_STAT) begin
            w_rd_inst = w_stat;
          end
        end else if (i_en && i_we && (i_addr == MMIO_TX)) begin
          if (!w_tx_full) begin
            w_tx_push = 1'b1;
          end else begin
            w_stall = 1'b1;
            w_next  = WAIT_TX;
          end
        end
      end
      WAIT_RX: begin
        w_stall = 1'b1;
        // Flags are registered, so a byte arriving this cycle waits for the next one.
        if (!w_rx_empty) begin
          w_rx_pop  = 1'b1;
          w_capture = 1'b1;
          w_next    = DONE_RX;
        end
      end
      DONE_RX: begin
        // The held load retires here from the captured byte; it is not re-decoded.
        if (i_en && !i_we) w_rd_inst = r_rd;
        w_next = IDLE;
      end
      WAIT_TX: begin
        w_stall = w_tx_full;
        if (!w_tx_full) begin
          w_tx_push = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (w_ram_we) r_mem[w_idx] <= i_wd;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd      <= '0;
      r_overrun <= 1'b0;
    end else begin
      if (w_capture)               r_rd      <= {24'b0, w_rx_head};
      if (i_rx_valid && w_rx_full) r_overrun <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_rx_push) r_rx_buf[r_rx_wp] <= i_rx_data;
    if (w_tx_push) r_tx_buf[r_tx_wp] <= i_wd[7:0];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_cnt <= '0;
    end else begin
      if (w_rx_push) r_rx_wp <= r_rx_wp + PTR_ONE;
      if (w_rx_pop)  r_rx_rp <= r_rx_rp + PTR_ONE;
      case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_cnt <= r_rx_cnt + CNT_ONE;
        2'b01:   r_rx_cnt <= r_rx_cnt - CNT_ONE;
        default: r_rx_cnt <= r_rx_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_cnt <= '0;
    end else begin
      if (w_tx_push) r_tx_wp <= r_tx_wp + PTR_ONE;
      if (w_tx_pop)  r_tx_rp <= r_tx_rp + PTR_ONE;
      case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_cnt <= r_tx_cnt + CNT_ONE;
        2'b01:   r_tx_cnt <= r_tx_cnt - CNT_ONE;
        default: r_tx_cnt <= r_tx_cnt;
      endcase
    end
  end

  assign o_rd_inst   = w_rd_inst;
  assign o_rd        = r_rd;
  assign o_stall     = w_stall && !reset;
  assign o_tx_valid  = !w_tx_empty;
  assign o_tx_data   = w_tx_empty ? 8'h00 : r_tx_buf[r_tx_rp];
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_memory_mmio.sv
// Bench for data_memory_mmio: directed driver tasks, expected-value queues, and a
// negedge monitor that owns every comparison and the pass/fail counters.
module tb_data_memory_mmio;

  localparam logic [31:0] MMIO_RX   = 32'hF000_0000;
  localparam logic [31:0] MMIO_TX   = 32'hF000_0001;
  localparam logic [31:0] MMIO_STAT = 32'hF000_0002;
  localparam int          MAX_WAIT  = 40;

  logic        clock;
  logic        reset;
  logic        en;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd_inst;
  logic [31:0] rd;
  logic        stall;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;
  logic [1:0]  dbg_state;

  data_memory_mmio dut (
    .clock      (clock),
    .reset      (reset),
    .i_en       (en),
    .i_we       (we),
    .i_addr     (addr),
    .i_wd       (wd),
    .o_rd_inst  (rd_inst),
    .o_rd       (rd),
    .o_stall    (stall),
    .i_rx_valid (rx_valid),
    .i_rx_data  (rx_data),
    .o_tx_valid (tx_valid),
    .o_tx_data  (tx_data),
    .i_tx_ready (tx_ready),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // ---------------- scoreboard state ----------------
  logic [31:0] exp_q[$];
  logic [7:0]  exp_tx_q[$];
  int          n_tests = 0;
  int          n_fail  = 0;

  logic        e_stall_en, e_stall;
  logic        e_rd_en;    logic [31:0] e_rd;
  logic        e_txv_en,   e_txv;
  logic        e_txd_en;   logic [7:0]  e_txd;
  logic        e_st_en;    logic [1:0]  e_st;
  logic        e_cnt_en;   int          e_cnt_act, e_cnt_exp;
  logic        e_final;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- monitor ----------------
  logic [31:0] m_exp;
  logic [7:0]  m_exp_tx;
  always @(negedge clock) begin
    if (!reset && en && !we && !stall) begin
      if (exp_q.size() == 0) cmp("load_unexpected", rd_inst, 32'hXXXX_XXXX);
      else begin
        m_exp = exp_q.pop_front();
        cmp("rd_inst", rd_inst, m_exp);
      end
    end
    if (!reset && tx_valid && tx_ready) begin
      if (exp_tx_q.size() == 0) cmp("tx_unexpected", {24'b0, tx_data}, 32'hXXXX_XXXX);
      else begin
        m_exp_tx = exp_tx_q.pop_front();
        cmp("tx_data_pop", {24'b0, tx_data}, {24'b0, m_exp_tx});
      end
    end
    if (e_stall_en) cmp("stall", {31'b0, stall}, {31'b0, e_stall});
    if (e_rd_en)    cmp("rd", rd, e_rd);
    if (e_txv_en)   cmp("tx_valid", {31'b0, tx_valid}, {31'b0, e_txv});
    if (e_txd_en)   cmp("tx_data", {24'b0, tx_data}, {24'b0, e_txd});
    if (e_st_en)    cmp("state", {30'b0, dbg_state}, {30'b0, e_st});
    if (e_cnt_en)   cmp("stall_cycles", e_cnt_act, e_cnt_exp);
    if (e_final) begin
      cmp("load_q_left", exp_q.size(), 0);
      cmp("tx_q_left", exp_tx_q.size(), 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
    e_stall_en = 1'b0; e_rd_en = 1'b0; e_txv_en = 1'b0;
    e_txd_en = 1'b0; e_st_en = 1'b0; e_cnt_en = 1'b0; e_final = 1'b0;
  endtask

  task automatic wait_done(input int exp_stalls);
    int s;
    s = 0;
    @(negedge clock);
    while (stall && s < MAX_WAIT) begin
      s++;
      step();
      @(negedge clock);
    end
    step();
    en = 1'b0; we = 1'b0;
    e_cnt_en = 1'b1; e_cnt_act = s; e_cnt_exp = exp_stalls;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] exp, input int es);
    step();
    en = 1'b1; we = 1'b0; addr = a;
    exp_q.push_back(exp);
    wait_done(es);
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input int es);
    step();
    en = 1'b1; we = 1'b1; addr = a; wd = d;
    if (a == MMIO_TX) exp_tx_q.push_back(d[7:0]);
    wait_done(es);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    step();
    rx_valid = 1'b1; rx_data = d;
  endtask

  task automatic expect_stall(input logic s);
    e_stall_en = 1'b1; e_stall = s;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    reset = 1'b1; en = 1'b0; we = 1'b0; addr = '0; wd = '0;
    rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    e_stall_en = 1'b0; e_stall = 1'b0; e_rd_en = 1'b0; e_rd = '0;
    e_txv_en = 1'b0; e_txv = 1'b0; e_txd_en = 1'b0; e_txd = '0;
    e_st_en = 1'b0; e_st = '0; e_cnt_en = 1'b0; e_cnt_act = 0; e_cnt_exp = 0;
    e_final = 1'b0;

    // reset state
    step();
    step();
    expect_stall(1'b0);
    e_rd_en = 1'b1; e_rd = 32'h0;
    e_txv_en = 1'b1; e_txv = 1'b0;
    e_txd_en = 1'b1; e_txd = 8'h00;
    e_st_en = 1'b1; e_st = 2'd0;
    step();
    reset = 1'b0;

    // RAM store/load, aliasing, MMIO decode of loads and dropped stores
    do_store(32'd5, 32'hDEAD_BEEF, 0);
    do_load(32'd5, 32'hDEAD_BEEF, 0);
    do_load(32'd5 + 32'd4096, 32'hDEAD_BEEF, 0);
    do_store(32'd7 + 32'd8192, 32'h1234_5678, 0);
    do_load(32'd7, 32'h1234_5678, 0);
    do_load(32'hF000_0005, 32'h0, 0);
    do_load(MMIO_TX, 32'h0, 0);
    do_store(MMIO_STAT, 32'hFFFF_FFFF, 0);
    do_store(MMIO_RX, 32'h0000_00AA, 0);
    do_load(MMIO_STAT, 32'h2, 0);

    // RX hit
    rx_byte(8'h41);
    rx_byte(8'h42);
    step(); rx_valid = 1'b0;
    step();
    step();
    do_load(MMIO_RX, 32'h41, 0);
    do_load(MMIO_RX, 32'h42, 0);
    do_load(MMIO_STAT, 32'h2, 0);

    // RX miss: 10 stall cycles, byte at t, completion at t+2
    step();
    en = 1'b1; we = 1'b0; addr = MMIO_RX;
    exp_q.push_back(32'h5A);
    expect_stall(1'b1);
    for (int i = 1; i < 10; i++) begin
      step(); expect_stall(1'b1);
      e_st_en = 1'b1; e_st = 2'd1;
    end
    rx_byte(8'h5A); expect_stall(1'b1);
    step(); rx_valid = 1'b0; expect_stall(1'b1);
    step(); expect_stall(1'b0);
    e_rd_en = 1'b1; e_rd = 32'h5A;
    e_st_en = 1'b1; e_st = 2'd2;
    step(); en = 1'b0;
    e_st_en = 1'b1; e_st = 2'd0;
    do_load(MMIO_STAT, 32'h2, 0);

    // TX full
    for (int i = 0; i < 16; i++) do_store(MMIO_TX, i, 0);
    step();
    en = 1'b1; we = 1'b1; addr = MMIO_TX; wd = 32'h10;
    exp_tx_q.push_back(8'h10);
    expect_stall(1'b1);
    step(); expect_stall(1'b1);
    e_st_en = 1'b1; e_st = 2'd3;
    step(); tx_ready = 1'b1; expect_stall(1'b1);
    step(); tx_ready = 1'b0; expect_stall(1'b0);
    step(); en = 1'b0; we = 1'b0;
    e_st_en = 1'b1; e_st = 2'd0;
    do_load(MMIO_STAT, 32'h0, 0);
    step(); tx_ready = 1'b1;
    for (int n = 0; n < MAX_WAIT; n++) begin
      step();
      if (!tx_valid) break;
    end
    tx_ready = 1'b0;
    e_txv_en = 1'b1; e_txv = 1'b0;
    e_txd_en = 1'b1; e_txd = 8'h00;

    // RX overrun: 17 bytes, first 16 kept
    for (int i = 0; i < 17; i++) rx_byte(8'h80 + 8'(i));
    step(); rx_valid = 1'b0;
    do_load(MMIO_STAT, 32'h7, 0);
    for (int i = 0; i < 16; i++) do_load(MMIO_RX, 32'h80 + i, 0);
    do_load(MMIO_STAT, 32'h6, 0);
    step(); e_rd_en = 1'b1; e_rd = 32'h5A;

    // reset while waiting on RX with TX bytes buffered
    do_store(MMIO_TX, 32'hA1, 0);
    do_store(MMIO_TX, 32'hA2, 0);
    step();
    en = 1'b1; we = 1'b0; addr = MMIO_RX;
    expect_stall(1'b1);
    step(); expect_stall(1'b1);
    e_st_en = 1'b1; e_st = 2'd1;
    e_txv_en = 1'b1; e_txv = 1'b1;
    step(); reset = 1'b1; expect_stall(1'b0);
    step(); reset = 1'b0;
    exp_tx_q.delete();
    addr = MMIO_STAT;
    exp_q.push_back(32'h2);
    expect_stall(1'b0);
    e_rd_en = 1'b1; e_rd = 32'h0;
    e_txv_en = 1'b1; e_txv = 1'b0;
    e_txd_en = 1'b1; e_txd = 8'h00;
    e_st_en = 1'b1; e_st = 2'd0;
    step(); en = 1'b0;
    do_load(32'd5, 32'hDEAD_BEEF, 0);
    do_load(32'd7, 32'h1234_5678, 0);

    step(); e_final = 1'b1;
    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_memory_mmio.md
# data_memory_mmio

Slave side of the data-memory port of the core's EX/MEM stage: a word-addressed RAM with 0-cycle (combinational) reads plus a UART MMIO window, each direction buffered by a FIFO. Accesses that cannot complete (RX FIFO empty on read, TX FIFO full on write) hold the pipeline via `stall` until they finish. Sits between the EX/MEM stage and the UART RX/TX byte engines.

## Interface
- `RAM_LOG2`, 12 — RAM depth is 2^RAM_LOG2 32-bit words.
- `FIFO_LOG2`, 4 — RX and TX FIFO depth is 2^FIFO_LOG2 bytes each.
- `MMIO_RX`, 32'hF000_0000 — RX data address; read only.
- `MMIO_TX`, 32'hF000_0001 — TX data address; write only.
- `MMIO_STAT`, 32'hF000_0002 — status address; read only.

Ports:
- `clock` input 1 — clock.
- `reset` input 1 — reset, synchronous, active-high.
- `m_data` interface, slave modport of DataMemoryWithMMIO:
  - `en` 1, `we` 1, `addr` 32, `wd` 32 are inputs.
  - `rd_inst` 32, `rd` 32, `stall` 1 are outputs.
- `rx_valid` input 1 — a byte from the UART receiver is present this cycle.
- `rx_data` input 8 — the received byte.
- `tx_valid` output 1 — TX FIFO is non-empty.
- `tx_data` output 8 — TX FIFO head; 0 when the FIFO is empty.
- `tx_ready` input 1 — the UART transmitter accepts `tx_data` this cycle.

## Operation
- Request = `en`=1. `we`=1 is a store, `we`=0 is a load.
- While `stall`=1 the master holds `en`, `we`, `addr` and `wd` stable.
- Address decode:
  - MMIO when `addr[31:28]`=4'hF.
  - Otherwise RAM, indexed by `addr[RAM_LOG2-1:0]`; upper bits are ignored, so addresses alias.
- RAM load: `rd_inst` = mem[idx] combinationally; `stall`=0.
- RAM store: mem[idx] <= `wd` at the clock edge; `stall`=0.
- STAT load returns {29'b0, overrun, tx_not_full, rx_not_empty}; never stalls.
- Loads from TX or from unmapped MMIO addresses return 0. Stores to RX, STAT or unmapped MMIO addresses are dropped. Neither ever stalls.
- RX FIFO:
  - Pushes `rx_data` when `rx_valid`=1 and the FIFO is not full.
  - `rx_valid`=1 while full drops the byte and sets the sticky `overrun` bit, cleared only by reset.
  - Simultaneous push and pop in one cycle is legal; the count is unchanged.
- TX FIFO: pops when `tx_valid`=1 and `tx_ready`=1. Simultaneous push and pop is legal.
- FSM states: IDLE, WAIT_RX, DONE_RX, WAIT_TX.
- IDLE:
  - RX load with RX FIFO non-empty: `rd_inst` = {24'b0, head}, pop; stay in IDLE; `stall`=0.
  - RX load with RX FIFO empty: `stall`=1; go to WAIT_RX.
  - TX store with TX FIFO not full: push `wd[7:0]`; `stall`=0.
  - TX store with TX FIFO full: `stall`=1; go to WAIT_TX.
- WAIT_RX:
  - `stall`=1.
  - When the RX FIFO is non-empty, capture head into `rd_reg` and pop; go to DONE_RX.
  - A byte pushed in this same cycle is visible no earlier than the next cycle.
- DONE_RX:
  - `stall`=0; `rd` = `rd_inst` = `rd_reg`.
  - The held request present this cycle is the one being completed; it is not re-executed.
  - Next state IDLE.
- WAIT_TX:
  - `stall` = TX FIFO full, evaluated this cycle.
  - When not full: push `wd[7:0]` at the edge and go to IDLE; `stall` is 0 in that cycle.
- `rd` outside DONE_RX equals `rd_reg`, which holds its last value.
- `rd_inst` is 0 when `en`=0 or `we`=1.

## Timing
- RAM accesses, STAT, and RX/TX accesses that hit (FIFO ready): 0 wait cycles.
- RX miss:
  - A byte arriving in cycle t is in the FIFO at t+1.
  - It is captured at the t+1 edge; the core sees `stall`=0 with valid `rd` at t+2.
- TX miss: `stall` drops in the first cycle the FIFO is not full; the push occurs at the end of that cycle.
- `stall` is combinational from the FSM state, FIFO flags, `en`, `we` and `addr`. It is forced to 0 while `reset`=1.
- Reset, including mid-wait:
  - FSM returns to IDLE; both FIFOs empty; `overrun`=0; `rd_reg`=0.
  - Outputs: `stall`=0, `rd`=0, `tx_valid`=0, `tx_data`=0.
  - RAM contents are not cleared.

## Test plan
- RAM: store 0xDEADBEEF to addr 5, then load addr 5 → `rd_inst`=0xDEADBEEF with 0 stall cycles. Load addr 5+2^RAM_LOG2 → same value (alias).
- RX hit: push 0x41 and 0x42, wait 2 cycles, load RX twice → 0x41 then 0x42, no stall. STAT afterwards reads 0x2.
- RX miss: load RX with the FIFO empty and hold `stall`=1 for 10 cycles. Pulse `rx_valid` with 0x5A at cycle t → `stall`=0 with `rd`=0x5A at t+2, and the FIFO is left empty.
- TX full: with `tx_ready`=0, store 16 bytes 0x00..0x0F, then store 0x10 → `stall`=1. Raise `tx_ready` for 1 cycle → `tx_data`=0x00 is popped, `stall` drops, and 0x10 ends up in the FIFO. Draining yields 0x01..0x10 in order.
- Overrun: push 17 bytes with no reads → STAT bit2=1, and the FIFO holds the first 16 bytes.
- Reset while in WAIT_RX, with bytes buffered in TX → `stall`=0, `tx_valid`=0, `rd`=0, STAT=0x2 the next cycle, and earlier RAM contents are preserved.
